// File: rtl/axi_stream_pkt_arbiter.sv
// Two-source AXI-Stream merger with packet-granular arbitration, alternating on ties,
// and a single registered output stage that also reports the beat count of each finished packet.
module axi_stream_pkt_arbiter #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BEAT_CNT_WD  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in0,
  input  logic [DATA_WD-1:0]      data_in0,
  input  logic [DATA_BYTE_WD-1:0] keep_in0,
  input  logic                    last_in0,
  output logic                    ready_in0,
  input  logic                    valid_in1,
  input  logic [DATA_WD-1:0]      data_in1,
  input  logic [DATA_BYTE_WD-1:0] keep_in1,
  input  logic                    last_in1,
  output logic                    ready_in1,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  output logic                    src_out,
  output logic                    pkt_done,
  output logic [BEAT_CNT_WD-1:0]  pkt_beats
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [BEAT_CNT_WD-1:0] CNT_MAX  = {BEAT_CNT_WD{1'b1}};
  localparam logic [BEAT_CNT_WD-1:0] CNT_ZERO = {BEAT_CNT_WD{1'b0}};
  localparam logic [BEAT_CNT_WD-1:0] CNT_ONE  = {{(BEAT_CNT_WD-1){1'b0}}, 1'b1};

  state_t                  state_r;
  logic                    gnt_r;
  logic                    ptr_r;
  logic [BEAT_CNT_WD-1:0]  beat_cnt_r;
  logic [BEAT_CNT_WD-1:0]  cnt_next_s;
  logic                    out_free_s;
  logic                    accept_s;
  logic                    sel_valid_s;
  logic                    sel_last_s;
  logic [DATA_WD-1:0]      sel_data_s;
  logic [DATA_BYTE_WD-1:0] sel_keep_s;

  function automatic logic [BEAT_CNT_WD-1:0] sat_inc(input logic [BEAT_CNT_WD-1:0] v);
    if (v == CNT_MAX) begin
      return CNT_MAX;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  // Handshake and source mux; only the granted source's inputs reach the datapath.
  always_comb begin
    out_free_s  = !valid_out || ready_out;
    ready_in0   = 1'b0;
    ready_in1   = 1'b0;
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    sel_data_s  = {DATA_WD{1'b0}};
    sel_keep_s  = {DATA_BYTE_WD{1'b0}};
    if (state_r == BUSY) begin
      ready_in0 = !gnt_r && out_free_s;
      ready_in1 = gnt_r && out_free_s;
    end else begin
      ready_in0 = 1'b0;
      ready_in1 = 1'b0;
    end
    if (gnt_r) begin
      sel_valid_s = valid_in1;
      sel_last_s  = last_in1;
      sel_data_s  = data_in1;
      sel_keep_s  = keep_in1;
    end else begin
      sel_valid_s = valid_in0;
      sel_last_s  = last_in0;
      sel_data_s  = data_in0;
      sel_keep_s  = keep_in0;
    end
    accept_s   = sel_valid_s && (ready_in0 || ready_in1);
    cnt_next_s = sat_inc(beat_cnt_r);
  end

  // Arbitration FSM, output register and packet statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      gnt_r      <= 1'b0;
      ptr_r      <= 1'b1;
      beat_cnt_r <= CNT_ZERO;
      valid_out  <= 1'b0;
      data_out   <= {DATA_WD{1'b0}};
      keep_out   <= {DATA_BYTE_WD{1'b0}};
      last_out   <= 1'b0;
      src_out    <= 1'b0;
      pkt_done   <= 1'b0;
      pkt_beats  <= CNT_ZERO;
    end else begin
      pkt_done <= 1'b0;
      if (accept_s) begin
        valid_out <= 1'b1;
        data_out  <= sel_data_s;
        keep_out  <= sel_keep_s;
        last_out  <= sel_last_s;
        src_out   <= gnt_r;
      end else if (ready_out) begin
        valid_out <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (valid_in0 || valid_in1) begin
            state_r    <= BUSY;
            beat_cnt_r <= CNT_ZERO;
            // On a tie the source that did not finish the previous packet wins.
            if (valid_in0 && valid_in1) begin
              gnt_r <= !ptr_r;
            end else begin
              gnt_r <= valid_in1;
            end
          end
        end
        BUSY: begin
          if (accept_s) begin
            beat_cnt_r <= cnt_next_s;
            if (sel_last_s) begin
              state_r   <= IDLE;
              ptr_r     <= gnt_r;
              pkt_done  <= 1'b1;
              pkt_beats <= cnt_next_s;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_stream_pkt_arbiter.sv
// Bench for axi_stream_pkt_arbiter: directed scenarios plus random traffic, checked
// against per-source packet queues and a handshake-level beat-count model.
module tb_axi_stream_pkt_arbiter;

  localparam int DW = 32;
  localparam int KW = 4;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_in0 = 1'b0, last_in0, ready_in0;
  logic valid_in1 = 1'b0, last_in1, ready_in1;
  logic [DW-1:0] data_in0, data_in1, data_out;
  logic [KW-1:0] keep_in0, keep_in1, keep_out;
  logic valid_out, last_out, src_out, pkt_done;
  logic ready_out = 1'b1;
  logic [CW-1:0] pkt_beats;

  axi_stream_pkt_arbiter #(.DATA_WD(DW), .DATA_BYTE_WD(KW), .BEAT_CNT_WD(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in0(valid_in0), .data_in0(data_in0), .keep_in0(keep_in0), .last_in0(last_in0), .ready_in0(ready_in0),
    .valid_in1(valid_in1), .data_in1(data_in1), .keep_in1(keep_in1), .last_in1(last_in1), .ready_in1(ready_in1),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out), .ready_out(ready_out),
    .src_out(src_out), .pkt_done(pkt_done), .pkt_beats(pkt_beats)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] d; logic [3:0] k; logic l; } beat_t;
  typedef struct { logic vo; logic src; logic [31:0] d; logic [3:0] k; logic l;
                   logic r0; logic r1; logic done; logic [1:0] beats; } obs_t;

  beat_t q0[$], q1[$], e0[$], e1[$];
  obs_t  log_q[$];
  obs_t  prev;
  int    n_vec = 0, n_err = 0;
  bit    stall0 = 1'b0, stall1 = 1'b0, rdy = 1'b1;
  int    inp_owner = -1, cnt = 0, pid = 100, guard, ndone, first1, last0;
  bit    exp_done = 1'b0, out_in_pkt = 1'b0, out_src = 1'b0, prev_stall = 1'b0, h0, h1, take;
  logic [1:0] exp_beats, hold_beats = 2'd0;
  logic [9:0] tie_vo = 10'b0111011100;

  function automatic logic [31:0] bdata(input int s, input int p, input int i);
    return {8'hA5, 8'(s), 8'(p), 8'(i)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_pkt(input int s, input int n, input int p);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.d = bdata(s, p, i);
      b.k = 4'($urandom_range(1, 15));
      b.l = (i == n - 1);
      if (s == 0) begin q0.push_back(b); e0.push_back(b); end
      else begin q1.push_back(b); e1.push_back(b); end
    end
  endtask

  task automatic reset_model();
    q0.delete(); q1.delete(); e0.delete(); e1.delete();
    inp_owner = -1; cnt = 0; exp_done = 1'b0; hold_beats = 2'd0;
    out_in_pkt = 1'b0; prev_stall = 1'b0;
  endtask

  task automatic drive();
    if (q0.size() > 0 && !stall0) begin
      valid_in0 = 1'b1; data_in0 = q0[0].d; keep_in0 = q0[0].k; last_in0 = q0[0].l;
    end else begin
      valid_in0 = 1'b0; data_in0 = 'x; keep_in0 = 'x; last_in0 = 1'bx;
    end
    if (q1.size() > 0 && !stall1) begin
      valid_in1 = 1'b1; data_in1 = q1[0].d; keep_in1 = q1[0].k; last_in1 = q1[0].l;
    end else begin
      valid_in1 = 1'b0; data_in1 = 'x; keep_in1 = 'x; last_in1 = 1'bx;
    end
    ready_out = rdy;
  endtask

  task automatic accept_in(input int s);
    beat_t b;
    if (s == 0) b = q0.pop_front(); else b = q1.pop_front();
    if (inp_owner >= 0) chk("input_interleave", 64'(s), 64'(inp_owner));
    inp_owner = s;
    cnt++;
    if (b.l) begin
      exp_done  = 1'b1;
      exp_beats = (cnt > 3) ? 2'd3 : 2'(cnt);
      cnt = 0;
      inp_owner = -1;
    end
  endtask

  task automatic check_out(input obs_t o);
    beat_t e;
    int avail;
    if (out_in_pkt) chk("out_interleave", 64'(o.src), 64'(out_src));
    avail = (o.src == 1'b1) ? e1.size() : e0.size();
    chk("out_beat_expected", 64'(avail > 0), 64'd1);
    if (avail > 0) begin
      if (o.src == 1'b1) e = e1.pop_front(); else e = e0.pop_front();
      chk("out_data", 64'(o.d), 64'(e.d));
      chk("out_keep", 64'(o.k), 64'(e.k));
      chk("out_last", 64'(o.l), 64'(e.l));
    end
    out_in_pkt = !o.l;
    out_src = o.src;
  endtask

  // One clock: drive at the falling edge, sample 1 ns later, update the model after the rising edge.
  task automatic cycle();
    obs_t o;
    @(negedge clk);
    drive();
    #1;
    o.vo = valid_out; o.src = src_out; o.d = data_out; o.k = keep_out; o.l = last_out;
    o.r0 = ready_in0; o.r1 = ready_in1; o.done = pkt_done; o.beats = pkt_beats;
    log_q.push_back(o);
    if (prev_stall) begin
      chk("hold_valid", 64'(valid_out), 64'd1);
      chk("hold_data", 64'(data_out), 64'(prev.d));
      chk("hold_keep", 64'(keep_out), 64'(prev.k));
      chk("hold_last", 64'(last_out), 64'(prev.l));
      chk("hold_src", 64'(src_out), 64'(prev.src));
    end
    chk("pkt_done", 64'(pkt_done), 64'(exp_done));
    if (exp_done) begin
      chk("pkt_beats", 64'(pkt_beats), 64'(exp_beats));
      hold_beats = exp_beats;
    end else begin
      chk("pkt_beats_hold", 64'(pkt_beats), 64'(hold_beats));
    end
    exp_done = 1'b0;
    chk("one_ready", 64'(ready_in0 & ready_in1), 64'd0);
    if (inp_owner == 0) chk("ready1_blocked", 64'(ready_in1), 64'd0);
    if (inp_owner == 1) chk("ready0_blocked", 64'(ready_in0), 64'd0);
    if (valid_out === 1'b1 && !rdy) chk("ready_backpressure", 64'(ready_in0 | ready_in1), 64'd0);
    h0 = (valid_in0 === 1'b1) && (ready_in0 === 1'b1);
    h1 = (valid_in1 === 1'b1) && (ready_in1 === 1'b1);
    take = (valid_out === 1'b1) && rdy;
    prev_stall = (valid_out === 1'b1) && !rdy;
    prev = o;
    @(posedge clk);
    if (h0) accept_in(0);
    if (h1) accept_in(1);
    if (take) check_out(o);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_out", 64'(valid_out), 64'd0);
    chk("rst_last_out", 64'(last_out), 64'd0);
    chk("rst_src_out", 64'(src_out), 64'd0);
    chk("rst_ready_in0", 64'(ready_in0), 64'd0);
    chk("rst_ready_in1", 64'(ready_in1), 64'd0);
    chk("rst_pkt_done", 64'(pkt_done), 64'd0);
    chk("rst_pkt_beats", 64'(pkt_beats), 64'd0);
    chk("rst_data_out", 64'(data_out), 64'd0);
    chk("rst_keep_out", 64'(keep_out), 64'd0);
    #1 rst_n = 1'b1;

    // Tie straight after reset: source 0 first, one bubble, then source 1.
    log_q.delete();
    add_pkt(0, 3, 1); add_pkt(1, 3, 2);
    repeat (10) cycle();
    for (int i = 0; i < 10; i++) chk("tie_valid", 64'(log_q[i].vo), 64'(tie_vo[i]));
    for (int i = 0; i < 3; i++) begin
      chk("tie_src0", 64'(log_q[2+i].src), 64'd0);
      chk("tie_data0", 64'(log_q[2+i].d), 64'(bdata(0, 1, i)));
      chk("tie_src1", 64'(log_q[6+i].src), 64'd1);
      chk("tie_data1", 64'(log_q[6+i].d), 64'(bdata(1, 2, i)));
    end
    chk("tie_done_a", 64'(log_q[4].done), 64'd1);
    chk("tie_beats_a", 64'(log_q[4].beats), 64'd3);
    chk("tie_done_b", 64'(log_q[8].done), 64'd1);
    chk("tie_beats_b", 64'(log_q[8].beats), 64'd3);

    // Sustained contention with single-beat packets.
    log_q.delete();
    for (int p = 0; p < 4; p++) begin add_pkt(0, 1, 10 + p); add_pkt(1, 1, 20 + p); end
    repeat (18) cycle();
    for (int k = 0; k < 8; k++) begin
      chk("alt_valid", 64'(log_q[2+2*k].vo), 64'd1);
      chk("alt_src", 64'(log_q[2+2*k].src), 64'(k % 2));
      chk("alt_data", 64'(log_q[2+2*k].d), 64'(bdata(k % 2, ((k % 2) != 0 ? 20 : 10) + k / 2, 0)));
      chk("alt_bubble", 64'(log_q[3+2*k].vo), 64'd0);
    end

    // Downstream backpressure for 4 cycles mid-packet.
    log_q.delete();
    add_pkt(0, 6, 30);
    for (int i = 0; i < 14; i++) begin
      rdy = (i < 3 || i > 6);
      cycle();
    end
    rdy = 1'b1;
    for (int i = 3; i < 7; i++) begin
      chk("bp_data", 64'(log_q[i].d), 64'(bdata(0, 30, 1)));
      chk("bp_ready0", 64'(log_q[i].r0), 64'd0);
    end
    for (int i = 8; i < 12; i++) chk("bp_resume", 64'(log_q[i].d), 64'(bdata(0, 30, i - 6)));
    chk("bp_beats", 64'(log_q[11].beats), 64'd3);

    // Source 0 stalls mid-packet while source 1 waits.
    log_q.delete();
    add_pkt(0, 5, 40);
    cycle();
    add_pkt(1, 2, 41);
    cycle(); cycle();
    stall0 = 1'b1;
    repeat (3) cycle();
    stall0 = 1'b0;
    repeat (12) cycle();
    for (int i = 1; i < 10; i++) chk("stall_ready1", 64'(log_q[i].r1), 64'd0);
    chk("stall_gap_a", 64'(log_q[4].vo), 64'd0);
    chk("stall_gap_b", 64'(log_q[5].vo), 64'd0);
    first1 = -1; last0 = -1;
    for (int i = 0; i < log_q.size(); i++) begin
      if (log_q[i].vo && log_q[i].src == 1'b1 && first1 < 0) first1 = i;
      if (log_q[i].vo && log_q[i].src == 1'b0 && log_q[i].l) last0 = i;
    end
    chk("stall_order", 64'(first1 > last0 && last0 >= 0), 64'd1);
    chk("stall_first1", 64'(log_q[11].d), 64'(bdata(1, 41, 0)));

    // Beat counter saturates at 3 for a 6-beat packet.
    log_q.delete();
    add_pkt(1, 6, 50);
    repeat (12) cycle();
    ndone = 0;
    for (int i = 0; i < log_q.size(); i++) if (log_q[i].done) ndone++;
    chk("sat_done_count", 64'(ndone), 64'd1);
    chk("sat_beats", 64'(log_q[7].beats), 64'd3);

    // Reset in the middle of a 4-beat packet.
    add_pkt(0, 4, 60);
    repeat (3) cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid_out", 64'(valid_out), 64'd0);
    chk("mrst_ready_in0", 64'(ready_in0), 64'd0);
    chk("mrst_ready_in1", 64'(ready_in1), 64'd0);
    chk("mrst_data_out", 64'(data_out), 64'd0);
    reset_model();
    @(posedge clk);
    #2 rst_n = 1'b1;
    log_q.delete();
    add_pkt(1, 2, 61);
    repeat (6) cycle();
    chk("mrst_idle_ready", 64'(log_q[0].r1), 64'd0);
    chk("mrst_grant1", 64'(log_q[1].r1), 64'd1);
    chk("mrst_first_src", 64'(log_q[2].src), 64'd1);
    chk("mrst_first_data", 64'(log_q[2].d), 64'(bdata(1, 61, 0)));

    // Random traffic with source stalls and downstream backpressure.
    for (int c = 0; c < 600; c++) begin
      if (q0.size() < 8 && $urandom_range(0, 3) == 0) begin add_pkt(0, $urandom_range(1, 5), pid); pid++; end
      if (q1.size() < 8 && $urandom_range(0, 3) == 0) begin add_pkt(1, $urandom_range(1, 5), pid); pid++; end
      stall0 = ($urandom_range(0, 4) == 0);
      stall1 = ($urandom_range(0, 4) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      cycle();
    end
    stall0 = 1'b0; stall1 = 1'b0; rdy = 1'b1;
    guard = 0;
    while ((q0.size() + q1.size() + e0.size() + e1.size()) > 0 && guard < 400) begin
      cycle();
      guard++;
    end
    chk("drain_timeout", 64'(guard < 400), 64'd1);
    chk("drain_left0", 64'(e0.size()), 64'd0);
    chk("drain_left1", 64'(e1.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_stream_pkt_arbiter.md
AXI_STREAM_PKT_ARBITER -- requirements
Module: axi_stream_pkt_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_WD, 32, data width in bits.
- DATA_BYTE_WD, DATA_WD/8, keep width.
- BEAT_CNT_WD, 16, packet beat counter width.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, input, 1, single clock, rising edge.
- rst_n, input, 1, reset: asynchronous, active-low.
- valid_in0, input, 1, source 0 beat valid.
- data_in0, input, DATA_WD, source 0 data.
- keep_in0, input, DATA_BYTE_WD, source 0 byte keep.
- last_in0, input, 1, source 0 end of packet.
- ready_in0, output, 1, source 0 accept.
- valid_in1, data_in1, keep_in1, last_in1, ready_in1: same as source 0, for source 1.
- valid_out, output, 1, merged beat valid.
- data_out, output, DATA_WD, merged data.
- keep_out, output, DATA_BYTE_WD, merged keep.
- last_out, output, 1, merged end of packet.
- ready_out, input, 1, downstream accept.
- src_out, output, 1, source index of the current output beat.
- pkt_done, output, 1, one-cycle pulse when a packet's last beat is accepted.
- pkt_beats, output, BEAT_CNT_WD, beat count of the finished packet; valid while pkt_done=1.

Function
REQ-003 The block SHALL merge two AXI-Stream sources into one output with packet-granular arbitration: packets are never interleaved.

REQ-004 The FSM SHALL have exactly two states:
- IDLE: no grant held.
- BUSY: grant held; register gnt (0/1) holds the owner.

REQ-005 In IDLE, the requester selection SHALL be:
- Only valid_in0=1: set gnt=0 and go to BUSY.
- Only valid_in1=1: set gnt=1 and go to BUSY.
- Both valid: choose the source not equal to the priority pointer ptr.
- Neither valid: stay in IDLE.

REQ-006 ready_in0 and ready_in1 SHALL both be 0 in IDLE, so each packet incurs exactly one arbitration bubble cycle.

REQ-007 In BUSY, ready_inX SHALL equal (gnt==X) && (!valid_out || ready_out); the non-granted ready SHALL be 0.

REQ-008 On an accepted input beat (valid_inX && ready_inX), the output register SHALL capture data, keep and last, set src_out=gnt and set valid_out=1 on the next edge, giving 1-cycle latency.

REQ-009 valid_out SHALL clear on an edge where ready_out=1 and no new beat is accepted.

REQ-010 Output beats SHALL hold stable while valid_out=1 and ready_out=0.

REQ-011 An accepted input beat with last=1 SHALL move the FSM BUSY->IDLE and set ptr=gnt, so the other source wins the next tie.

REQ-012 A single-beat packet SHALL follow the same path as a multi-beat packet: IDLE, BUSY for one beat, then IDLE.

REQ-013 New requests arriving in the same cycle as a last-beat accept SHALL be evaluated in the following IDLE cycle, not in that cycle.

REQ-014 The beat counter SHALL work as follows:
- It clears on entry to BUSY.
- It increments on each accepted input beat.
- It saturates at 2^BEAT_CNT_WD-1 and does not wrap.

REQ-015 On the edge after a last-beat accept, pkt_done SHALL be 1 for exactly one cycle, with pkt_beats = the final count including the last beat.

REQ-016 pkt_beats SHALL hold its value until the next pkt_done.

REQ-017 valid_inX deasserting mid-packet SHALL NOT release the grant; the block waits in BUSY until that source completes its packet.

REQ-018 keep and data SHALL pass through unmodified; the block performs no keep compaction and no keep checking.

REQ-019 X on the inputs of a non-granted source SHALL NOT propagate to any output.

Reset
REQ-020 With rst_n=0, the following SHALL hold asynchronously:
- FSM=IDLE, gnt=0, ptr=1 (source 0 wins the first tie).
- valid_out=0, last_out=0, src_out=0.
- ready_in0=0, ready_in1=0.
- pkt_done=0, pkt_beats=0, beat counter=0.
- data_out=0, keep_out=0.

REQ-021 Reset asserted mid-packet SHALL discard the partial packet.

REQ-022 After rst_n rises, the first arbitration SHALL occur on the first rising edge with rst_n=1.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Tie after reset: both sources present 3-beat packets together, ready_out=1 -> output shows src0 beats 1-3, then one bubble, then src1 beats 1-3. pkt_done pulses twice, with pkt_beats=3 each time.
- Sustained contention: both sources continuously valid with 1-beat packets -> src_out alternates 0,1,0,1 and each packet occupies 2 cycles.
- Backpressure: ready_out=0 for 4 cycles mid-packet -> data_out, keep_out and last_out are stable and ready_in of the granted source is 0. Beats resume in order with none lost or duplicated.
- Source stall mid-packet: valid_in0 drops for 3 cycles while valid_in1=1 -> grant stays 0, ready_in1 stays 0, and no src1 beat appears until last_in0 has been accepted.
- Saturation: with BEAT_CNT_WD=2, send a 6-beat packet -> pkt_beats=3.
- Reset mid-packet: assert rst_n=0 after beat 2 of 4 -> valid_out=0 immediately and ready_in0/1=0. After release with only source 1 valid, source 1 is granted first.
